gshare_spec_predictor: RTL and testbench
========================================

# gshare_spec_predictor

Parametrised gshare branch direction predictor with speculative global history, mispredict history recovery, configurable counter width and a sequential PHT initialisation sweep. It sits beside the IF stage: lookups come from fetch, history repair comes from the branch-resolve stage, and counter training comes from commit. The PHT read is registered, so the table maps onto synchronous RAM.

## Interface
- INDEX_BITS, 10: PHT index width; PHT depth = 2^INDEX_BITS.
- HIST_BITS, 10: global history length; legal range 1..INDEX_BITS.
- CTR_BITS, 2: saturating counter width; legal range 2..4.
- USE_HISTORY, 1: 1 = gshare index; 0 = bimodal index, with history ignored in indexing but still tracked.

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- lookup_valid  in  1  fetch presents a conditional branch
- lookup_pc  in  32  branch PC
- lookup_ready  out  1  predictor accepts lookups; 0 while initialising
- pred_valid  out  1  prediction valid one cycle after an accepted lookup
- pred_taken  out  1  predicted direction
- pred_ghr  out  HIST_BITS  speculative history used to form the index; fetch saves it with the branch
- recover_valid  in  1  mispredict; repair history
- recover_ghr  in  HIST_BITS  pred_ghr saved with the mispredicted branch
- recover_taken  in  1  actual outcome of that branch
- update_valid  in  1  train counter (commit)
- update_pc  in  32  committed branch PC
- update_ghr  in  HIST_BITS  pred_ghr saved with that branch
- update_taken  in  1  actual outcome
- spec_ghr_out  out  HIST_BITS  current speculative history (debug/checkpoint)

## Operation
- **Index:** lookup_pc[INDEX_BITS+1:2] XOR zero-extended spec_ghr. Update uses update_ghr in place of spec_ghr. With USE_HISTORY=0 the XOR term is 0.
- **FSM states:**
  - INIT: entered on rst. A sweep counter writes WNT = 2^(CTR_BITS-1)-1 to entries 0..2^INDEX_BITS-1, one entry per cycle. lookup_ready=0. lookup_valid and update_valid are ignored. recover_valid is honoured.
  - INIT transitions to READY in the cycle after the last entry is written.
  - READY: lookup_ready=1.
- **Lookup:** accepted when lookup_valid && lookup_ready. On acceptance, register the index, register spec_ghr into pred_ghr, and read the PHT.
- **Prediction:** next cycle, pred_valid=1 and pred_taken = MSB of the counter.
- **Speculative history:** at the edge ending a pred_valid cycle, spec_ghr <= {spec_ghr[HIST_BITS-2:0], pred_taken}. For HIST_BITS=1 the new value is pred_taken.
- **Recovery:** spec_ghr <= {recover_ghr[HIST_BITS-2:0], recover_taken}.
  - Recovery overrides a same-cycle speculative shift.
  - pred_valid in the recovery cycle still appears, but its history shift is discarded.
- **Training:** on update_valid, read-modify-write counter[update index].
  - update_taken=1: increment, saturating at 2^CTR_BITS-1.
  - update_taken=0: decrement, saturating at 0.
  - Completes in one cycle.
- **Collisions:**
  - Lookup and update to the same index in the same cycle: the lookup returns the pre-update value.
  - Two consecutive updates to the same index must compound; there is no lost update.
- **Reset mid-operation:** restarts INIT from entry 0. An in-flight prediction is dropped: pred_valid=0 in the next cycle.

## Timing
- **Reset values:** lookup_ready=0, pred_valid=0, pred_taken=0, pred_ghr=0, spec_ghr_out=0; FSM=INIT; sweep counter=0.
- **Init duration:** lookup_ready rises 2^INDEX_BITS cycles after rst deasserts (1024 cycles at defaults).
- **Lookup latency:** 1 cycle.
  - Lookup accepted in cycle N gives pred_valid in cycle N+1.
  - A back-to-back lookup in N+1 indexes with history that does not yet include branch N's prediction.
  - A lookup in N+2 sees it.
- **Recovery latency:** spec_ghr_out shows the repaired history in the cycle after recover_valid. A lookup in that same cycle uses the pre-repair history.
- **Update latency:** the new counter value is visible to lookups accepted from the cycle after update_valid.
- **Outputs:** registered, except lookup_ready and spec_ghr_out, which are direct state.

## Test plan
- **Init sweep:** hold rst 2 cycles, release -> lookup_ready=0 for exactly 1024 cycles, then 1. Every entry reads 2'b01; lookup of pc 0x100 gives pred_taken=0.
- **Saturation:** with spec_ghr=0, three updates pc=0x40, ghr=0, taken=1 -> counter 01→10→11→11; a following lookup gives pred_taken=1. Then three not-taken updates -> 11→10→01→00, and pred_taken=0.
- **Speculative history:** four lookups spaced 2 cycles apart, all predicting taken -> spec_ghr_out goes 0x000→0x001→0x003→0x007→0x00F; each pred_ghr equals the prior value.
- **Recovery priority:** recover_valid with recover_ghr=0x155, taken=0, in the same cycle as pred_valid with pred_taken=1 -> spec_ghr_out=0x2AA next cycle.
- **Collision:** update at index 5 (01→10) in the same cycle as a lookup to index 5 -> pred_taken=0. A lookup the next cycle -> pred_taken=1.
- **Mid-operation reset:** assert rst while pred_valid is pending and after training index 5 to 11 -> pred_valid=0, lookup_ready=0. After 1024 cycles index 5 reads 01, and spec_ghr_out=0.

Source files
------------

// File: rtl/gshare_spec_predictor_if.sv
// gshare_spec_predictor_if: fetch / resolve / commit bundle
// for the speculative gshare predictor.
interface gshare_spec_predictor_if #(
    parameter int HIST_BITS = 10
);
    logic                 lookup_valid;
    logic [31:0]          lookup_pc;
    logic                 lookup_ready;
    logic                 pred_valid;
    logic                 pred_taken;
    logic [HIST_BITS-1:0] pred_ghr;
    logic                 recover_valid;
    logic [HIST_BITS-1:0] recover_ghr;
    logic                 recover_taken;
    logic                 update_valid;
    logic [31:0]          update_pc;
    logic [HIST_BITS-1:0] update_ghr;
    logic                 update_taken;
    logic [HIST_BITS-1:0] spec_ghr_out;

    modport master (
        output lookup_valid, lookup_pc,
        input  lookup_ready, pred_valid, pred_taken, pred_ghr,
        output recover_valid, recover_ghr, recover_taken,
        output update_valid, update_pc, update_ghr, update_taken,
        input  spec_ghr_out
    );

    modport slave (
        input  lookup_valid, lookup_pc,
        output lookup_ready, pred_valid, pred_taken, pred_ghr,
        input  recover_valid, recover_ghr, recover_taken,
        input  update_valid, update_pc, update_ghr, update_taken,
        output spec_ghr_out
    );
endinterface

// File: rtl/gshare_spec_predictor.sv
// gshare_spec_predictor: gshare direction predictor with
// speculative global history, mispredict repair and PHT init sweep.
module gshare_spec_predictor #(
    parameter int INDEX_BITS  = 10,
    parameter int HIST_BITS   = 10,
    parameter int CTR_BITS    = 2,
    parameter int USE_HISTORY = 1
) (
    input logic clk,
    input logic rst,
    gshare_spec_predictor_if.slave bus
);
    localparam int DEPTH = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] WNT =
        CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CMAX = '1;
    localparam logic [INDEX_BITS-1:0] LAST =
        INDEX_BITS'(DEPTH - 1);

    typedef enum logic {
        S_INIT,
        S_READY
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [INDEX_BITS-1:0] sweep;
    logic [CTR_BITS-1:0]   pht [DEPTH];
    logic [HIST_BITS-1:0]  spec_ghr;
    logic                  ready;
    logic                  init_we;
    logic                  lk_fire;
    logic                  up_fire;
    logic [INDEX_BITS-1:0] lk_idx;
    logic [INDEX_BITS-1:0] up_idx;
    logic [CTR_BITS-1:0]   up_ctr;
    logic [CTR_BITS-1:0]   up_nxt;
    logic                  pred_valid_q;
    logic                  pred_taken_q;
    logic [HIST_BITS-1:0]  pred_ghr_q;
    logic                  unused_pc;

    // Shift one outcome into a history; works for HIST_BITS=1 too.
    function automatic logic [HIST_BITS-1:0] shift_in(
        input logic [HIST_BITS-1:0] h,
        input logic                 b
    );
        logic [HIST_BITS:0] t;
        t = {h, b};
        return t[HIST_BITS-1:0];
    endfunction

    // History contribution to the index (zero in bimodal mode).
    function automatic logic [INDEX_BITS-1:0] hist_term(
        input logic [HIST_BITS-1:0] h
    );
        if (USE_HISTORY != 0) begin
            return INDEX_BITS'(h);
        end
        return '0;
    endfunction

    assign lk_idx = bus.lookup_pc[INDEX_BITS+1:2] ^ hist_term(spec_ghr);
    assign up_idx = bus.update_pc[INDEX_BITS+1:2] ^ hist_term(bus.update_ghr);
    assign lk_fire = bus.lookup_valid && ready;
    assign up_fire = bus.update_valid && ready;

    assign unused_pc = ^{bus.lookup_pc[31:INDEX_BITS+2],
                         bus.lookup_pc[1:0],
                         bus.update_pc[31:INDEX_BITS+2],
                         bus.update_pc[1:0]};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: leave INIT once the last entry is written.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_INIT:  if (sweep == LAST) state_nxt = S_READY;
            S_READY: state_nxt = S_READY;
            default: state_nxt = S_INIT;
        endcase
    end

    // FSM outputs.
    always_comb begin
        ready   = 1'b0;
        init_we = 1'b0;
        unique case (state)
            S_INIT:  init_we = 1'b1;
            S_READY: ready   = 1'b1;
            default: init_we = 1'b1;
        endcase
    end

    // Init sweep pointer, one entry per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sweep <= '0;
        end else if (init_we) begin
            sweep <= sweep + 1'b1;
        end
    end

    // Saturating counter step for the committed branch.
    always_comb begin
        up_ctr = pht[up_idx];
        up_nxt = up_ctr;
        if (bus.update_taken) begin
            if (up_ctr != CMAX) up_nxt = up_ctr + 1'b1;
        end else begin
            if (up_ctr != '0) up_nxt = up_ctr - 1'b1;
        end
    end

    // PHT write port: init sweep, else training.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (init_we) begin
                pht[sweep] <= WNT;
            end else if (up_fire) begin
                pht[up_idx] <= up_nxt;
            end
        end
    end

    // Registered PHT read; sees the pre-update counter on collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_ghr_q   <= '0;
        end else begin
            pred_valid_q <= lk_fire;
            if (lk_fire) begin
                pred_taken_q <= pht[lk_idx][CTR_BITS-1];
                pred_ghr_q   <= spec_ghr;
            end
        end
    end

    // Speculative history: repair wins over the speculative shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_ghr <= '0;
        end else if (bus.recover_valid) begin
            spec_ghr <= shift_in(bus.recover_ghr, bus.recover_taken);
        end else if (pred_valid_q) begin
            spec_ghr <= shift_in(spec_ghr, pred_taken_q);
        end
    end

    assign bus.lookup_ready = ready;
    assign bus.pred_valid   = pred_valid_q;
    assign bus.pred_taken   = pred_taken_q;
    assign bus.pred_ghr     = pred_ghr_q;
    assign bus.spec_ghr_out = spec_ghr;
endmodule

// File: tb/tb_gshare_spec_predictor.sv
// tb_gshare_spec_predictor: directed vectors, scoreboard queue
// filled at issue, drained by a monitor on pred_valid.
module tb_gshare_spec_predictor;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    gshare_spec_predictor_if #(.HIST_BITS(10)) bus ();

    gshare_spec_predictor #(
        .INDEX_BITS (10),
        .HIST_BITS  (10),
        .CTR_BITS   (2),
        .USE_HISTORY(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic       taken;
        logic [9:0] ghr;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Monitor: every prediction must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.pred_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_pred", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("pred_taken", 32'(bus.pred_taken), 32'(e.taken));
                chk("pred_ghr", 32'(bus.pred_ghr), 32'(e.ghr));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.lookup_valid  = 1'b0;
        bus.lookup_pc     = '0;
        bus.recover_valid = 1'b0;
        bus.recover_ghr   = '0;
        bus.recover_taken = 1'b0;
        bus.update_valid  = 1'b0;
        bus.update_pc     = '0;
        bus.update_ghr    = '0;
        bus.update_taken  = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic t,
                          input logic [9:0] g);
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = pc;
        q.push_back({t, g});
        step();
        bus.lookup_valid = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic [9:0] g,
                          input logic t);
        bus.update_valid = 1'b1;
        bus.update_pc    = pc;
        bus.update_ghr   = g;
        bus.update_taken = t;
        step();
        bus.update_valid = 1'b0;
    endtask

    task automatic recover(input logic [9:0] g, input logic t);
        bus.recover_valid = 1'b1;
        bus.recover_ghr   = g;
        bus.recover_taken = t;
        step();
        bus.recover_valid = 1'b0;
    endtask

    // Count not-ready cycles after reset release, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.lookup_ready) break;
            n++;
        end
    endtask

    logic [9:0] hist_seq [5];
    int n;

    initial begin
        hist_seq[0] = 10'h000;
        hist_seq[1] = 10'h001;
        hist_seq[2] = 10'h003;
        hist_seq[3] = 10'h007;
        hist_seq[4] = 10'h00F;
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        chk("rst_ready", 32'(bus.lookup_ready), 32'd0);
        chk("rst_pred_valid", 32'(bus.pred_valid), 32'd0);
        chk("rst_pred_taken", 32'(bus.pred_taken), 32'd0);
        chk("rst_pred_ghr", 32'(bus.pred_ghr), 32'd0);
        chk("rst_spec_ghr", 32'(bus.spec_ghr_out), 32'd0);
        rst = 1'b0;
        wait_ready(n);
        chk("init_cycles", 32'(n), 32'd1024);
        step();

        lookup(32'h100, 1'b0, 10'h000);
        step();

        update(32'h40, 10'h000, 1'b1);
        update(32'h40, 10'h000, 1'b1);
        update(32'h40, 10'h000, 1'b1);
        lookup(32'h40, 1'b1, 10'h000);
        update(32'h40, 10'h000, 1'b0);
        lookup(32'h44, 1'b1, 10'h001);
        update(32'h40, 10'h000, 1'b0);
        update(32'h40, 10'h000, 1'b0);
        lookup(32'h4C, 1'b0, 10'h003);
        recover(10'h000, 1'b0);
        chk("recover_clear", 32'(bus.spec_ghr_out), 32'h000);

        for (int k = 0; k < 5; k++) begin
            update(32'h200, hist_seq[k], 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            chk("spec_hist_pre", 32'(bus.spec_ghr_out), 32'(hist_seq[k]));
            lookup(32'h200, 1'b1, hist_seq[k]);
            step();
        end
        chk("spec_hist_end", 32'(bus.spec_ghr_out), 32'h00F);

        lookup(32'h200, 1'b1, 10'h00F);
        bus.recover_valid = 1'b1;
        bus.recover_ghr   = 10'h155;
        bus.recover_taken = 1'b0;
        lookup(32'h200, 1'b1, 10'h00F);
        bus.recover_valid = 1'b0;
        chk("recover_priority", 32'(bus.spec_ghr_out), 32'h2AA);
        step();
        chk("after_recover_shift", 32'(bus.spec_ghr_out), 32'h155);

        recover(10'h000, 1'b0);
        chk("collide_pre_ghr", 32'(bus.spec_ghr_out), 32'h000);
        bus.update_valid = 1'b1;
        bus.update_pc    = 32'h14;
        bus.update_ghr   = 10'h000;
        bus.update_taken = 1'b1;
        lookup(32'h14, 1'b0, 10'h000);
        bus.update_valid = 1'b0;
        lookup(32'h14, 1'b1, 10'h000);
        update(32'h14, 10'h000, 1'b1);
        chk("collide_post_ghr", 32'(bus.spec_ghr_out), 32'h001);

        rst = 1'b1;
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = 32'h14;
        step();
        bus.lookup_valid = 1'b0;
        chk("midrst_pred_valid", 32'(bus.pred_valid), 32'd0);
        chk("midrst_ready", 32'(bus.lookup_ready), 32'd0);
        step();
        rst = 1'b0;
        wait_ready(n);
        chk("reinit_cycles", 32'(n), 32'd1024);
        step();
        chk("reinit_spec_ghr", 32'(bus.spec_ghr_out), 32'h000);
        lookup(32'h14, 1'b0, 10'h000);
        step();

        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
